// File: rtl/issue_sched_pkg.sv
// Shared definitions for the issue scheduler: default sizes, slot ids,
// issue-count encoding and a small popcount helper.
package issue_sched_pkg;

    localparam int ISSQ_DEPTH   = 4;
    localparam int PC_BUS       = 32;
    localparam int REG_ADDR_BUS = 5;

    localparam int ISS_SLOT_A = 0;
    localparam int ISS_SLOT_B = 1;

    // Instructions issued in one cycle; also the queue pop amount.
    typedef enum logic [1:0] {
        ISS_NONE = 2'd0,
        ISS_ONE  = 2'd1,
        ISS_TWO  = 2'd2
    } iss_cnt_e;

    // Number of set bits in a 2-bit valid vector.
    function automatic logic [1:0] pop2(input logic [1:0] v);
        return {v[1] & v[0], v[1] ^ v[0]};
    endfunction

endpackage

// File: rtl/issue_sched_if.sv
// Decode-to-scheduler and scheduler-to-FAB signal bundle.
// master: decode/pipeline side; slave: issue_sched.
interface issue_sched_if #(
    parameter int QDEPTH = 4,
    parameter int PC_W   = 32,
    parameter int RA_W   = 5
);
    localparam int IW = $clog2(QDEPTH);

    logic [1:0]      enq_valid;
    logic [PC_W-1:0] enq_pc0;
    logic [PC_W-1:0] enq_pc1;
    logic [PC_W-1:0] enq_npc0;
    logic [PC_W-1:0] enq_npc1;
    logic [RA_W-1:0] enq_rs1_0;
    logic [RA_W-1:0] enq_rs2_0;
    logic [RA_W-1:0] enq_rd_0;
    logic [RA_W-1:0] enq_rs1_1;
    logic [RA_W-1:0] enq_rs2_1;
    logic [RA_W-1:0] enq_rd_1;
    logic [1:0]      enq_we;
    logic [1:0]      enq_br;
    logic            enq_ready;
    logic            stop;
    logic            flush;
    logic [1:0]      iss_valid;
    logic [PC_W-1:0] iss_pc0;
    logic [PC_W-1:0] iss_pc1;
    logic [PC_W-1:0] iss_npc0;
    logic [PC_W-1:0] iss_npc1;
    logic [IW-1:0]   iss_idx0;
    logic [IW-1:0]   iss_idx1;
    logic            iss_num0;
    logic            iss_num1;

    modport master (
        output enq_valid, enq_pc0, enq_pc1, enq_npc0, enq_npc1,
        output enq_rs1_0, enq_rs2_0, enq_rd_0,
        output enq_rs1_1, enq_rs2_1, enq_rd_1,
        output enq_we, enq_br, stop, flush,
        input  enq_ready, iss_valid, iss_pc0, iss_pc1,
        input  iss_npc0, iss_npc1, iss_idx0, iss_idx1,
        input  iss_num0, iss_num1
    );

    modport slave (
        input  enq_valid, enq_pc0, enq_pc1, enq_npc0, enq_npc1,
        input  enq_rs1_0, enq_rs2_0, enq_rd_0,
        input  enq_rs1_1, enq_rs2_1, enq_rd_1,
        input  enq_we, enq_br, stop, flush,
        output enq_ready, iss_valid, iss_pc0, iss_pc1,
        output iss_npc0, iss_npc1, iss_idx0, iss_idx1,
        output iss_num0, iss_num1
    );

endinterface

// File: rtl/issue_sched_queue.sv
// Dual-write / dual-read circular issue queue (pointers, count, flush).
// Ports: clk, rst, flush, push[1:0], wdata0/1, pop (0..2) in;
//        rdata0/1 (head, head+1), head/head1 idx, count, ready out.
module issue_sched_queue
    import issue_sched_pkg::*;
#(
    parameter int QDEPTH = 4,
    parameter int W      = 8,
    localparam int IW    = $clog2(QDEPTH),
    localparam int CW    = $clog2(QDEPTH + 1)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          flush,
    input  logic [1:0]    push,
    input  logic [W-1:0]  wdata0,
    input  logic [W-1:0]  wdata1,
    input  logic [1:0]    pop,
    output logic [W-1:0]  rdata0,
    output logic [W-1:0]  rdata1,
    output logic [IW-1:0] head,
    output logic [IW-1:0] head1,
    output logic [CW-1:0] count,
    output logic          ready
);

    logic [W-1:0]  mem [QDEPTH];
    logic [IW-1:0] tail;
    logic [IW-1:0] tail1;
    logic [1:0]    acc;
    logic [1:0]    n_push;

    // Room for a full pair is required before anything is taken.
    assign ready  = count <= CW'(QDEPTH - 2);
    assign acc    = push & {2{ready & ~flush}};
    assign n_push = pop2(acc);
    assign head1  = head + IW'(1);
    assign tail1  = tail + IW'(1);
    assign rdata0 = mem[head];
    assign rdata1 = mem[head1];

    always_ff @(posedge clk) begin
        if (acc[0]) mem[tail]  <= wdata0;
        if (acc[1]) mem[tail1] <= wdata1;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else if (flush) begin
            head  <= tail;
            count <= '0;
        end else begin
            head  <= head + IW'(pop);
            tail  <= tail + IW'(n_push);
            count <= count + CW'(n_push) - CW'(pop);
        end
    end

endmodule

// File: rtl/issue_sched.sv
// Dual-issue scheduler: in-order issue from a small queue to FAB0/FAB1
// with a one-cycle busy scoreboard (no forwarding) and the FAB num bit.
// Ports: clk, rst (async, active-high); bus = issue_sched_if.slave
//        (enq_* / stop / flush in, enq_ready / iss_* out).
// Build option: DUAL_ISSUE_EN enables slot-B issue and the seq toggle.
module issue_sched
    import issue_sched_pkg::*;
#(
    parameter int QDEPTH = ISSQ_DEPTH,
    parameter int PC_W   = PC_BUS,
    parameter int RA_W   = REG_ADDR_BUS
) (
    input  logic         clk,
    input  logic         rst,
    issue_sched_if.slave bus
);

    localparam int IW = $clog2(QDEPTH);
    localparam int CW = $clog2(QDEPTH + 1);

    typedef struct packed {
        logic [PC_W-1:0] pc;
        logic [PC_W-1:0] npc;
        logic [RA_W-1:0] rs1;
        logic [RA_W-1:0] rs2;
        logic [RA_W-1:0] rd;
        logic            we;
        logic            br;
    } entry_t;

    typedef struct packed {
        logic            valid;
        logic [RA_W-1:0] rd;
    } sb_t;

    localparam int EW = $bits(entry_t);

    entry_t        e_in0;
    entry_t        e_in1;
    entry_t        ent_a;
    entry_t        ent_b;
    logic [EW-1:0] rd_a;
    logic [EW-1:0] rd_b;
    logic [IW-1:0] idx_a;
    logic [IW-1:0] idx_b;
    logic [CW-1:0] count;
    logic          q_ready;
    iss_cnt_e      n_iss;
    sb_t           sb [2];
    logic          hz_a;
    logic          hz_b;
    logic          raw;
    logic          waw;
    logic          b_ok;
    logic          iss_a;
    logic          iss_b;
    logic          seq;
    logic          unused_bits;

    assign e_in0 = '{pc: bus.enq_pc0, npc: bus.enq_npc0,
                     rs1: bus.enq_rs1_0, rs2: bus.enq_rs2_0,
                     rd: bus.enq_rd_0, we: bus.enq_we[0],
                     br: bus.enq_br[0]};
    assign e_in1 = '{pc: bus.enq_pc1, npc: bus.enq_npc1,
                     rs1: bus.enq_rs1_1, rs2: bus.enq_rs2_1,
                     rd: bus.enq_rd_1, we: bus.enq_we[1],
                     br: bus.enq_br[1]};

    issue_sched_queue #(
        .QDEPTH(QDEPTH),
        .W     (EW)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (bus.flush),
        .push  (bus.enq_valid),
        .wdata0(e_in0),
        .wdata1(e_in1),
        .pop   (n_iss),
        .rdata0(rd_a),
        .rdata1(rd_b),
        .head  (idx_a),
        .head1 (idx_b),
        .count (count),
        .ready (q_ready)
    );

    assign ent_a = entry_t'(rd_a);
    assign ent_b = entry_t'(rd_b);

    // A source is blocked while last cycle's producer is still
    // in the FAB register; x0 is never busy.
    always_comb begin
        hz_a = 1'b0;
        hz_b = 1'b0;
        for (int i = 0; i < 2; i++) begin
            if (sb[i].valid && sb[i].rd != '0) begin
                if (sb[i].rd == ent_a.rs1 || sb[i].rd == ent_a.rs2)
                    hz_a = 1'b1;
                if (sb[i].rd == ent_b.rs1 || sb[i].rd == ent_b.rs2)
                    hz_b = 1'b1;
            end
        end
    end

    // Intra-pair hazards: B cannot see A's result in the same cycle,
    // and two writers of one rd would race in the regfile.
    assign raw = ent_a.we && ent_a.rd != '0 &&
                 (ent_a.rd == ent_b.rs1 || ent_a.rd == ent_b.rs2);
    assign waw = ent_a.we && ent_b.we &&
                 ent_a.rd == ent_b.rd && ent_a.rd != '0;

    assign iss_a = count >= CW'(1) && !bus.stop &&
                   !bus.flush && !hz_a;
    assign b_ok  = count >= CW'(2) && !ent_a.br &&
                   !hz_b && !raw && !waw;

`ifdef DUAL_ISSUE_EN
    assign iss_b       = iss_a && b_ok;
    assign unused_bits = ent_b.br;
`else
    assign iss_b       = 1'b0;
    assign unused_bits = ^{ent_b.br, b_ok};
`endif

    assign n_iss = iss_cnt_e'({iss_a & iss_b, iss_a ^ iss_b});

    // Mirrors the FAB one-cycle register: holds under stop.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sb[ISS_SLOT_A] <= '0;
            sb[ISS_SLOT_B] <= '0;
        end else if (!bus.stop) begin
            sb[ISS_SLOT_A] <= '{valid: iss_a & ent_a.we,
                                rd: ent_a.rd};
            sb[ISS_SLOT_B] <= '{valid: iss_b & ent_b.we,
                                rd: ent_b.rd};
        end
    end

`ifdef DUAL_ISSUE_EN
    // A single issue leaves the older FAB holding the odd one out,
    // so the ordering bit swaps sides.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            seq <= 1'b0;
        else if (n_iss == ISS_ONE)
            seq <= ~seq;
    end
`else
    assign seq = 1'b0;
`endif

    assign bus.enq_ready = q_ready;
    assign bus.iss_valid = {iss_b, iss_a};
    assign bus.iss_pc0   = iss_a ? ent_a.pc  : '0;
    assign bus.iss_npc0  = iss_a ? ent_a.npc : '0;
    assign bus.iss_idx0  = iss_a ? idx_a     : '0;
    assign bus.iss_num0  = iss_a & seq;
    assign bus.iss_pc1   = iss_b ? ent_b.pc  : '0;
    assign bus.iss_npc1  = iss_b ? ent_b.npc : '0;
    assign bus.iss_idx1  = iss_b ? idx_b     : '0;
    assign bus.iss_num1  = iss_b & ~seq;

endmodule

// File: tb/tb_issue_sched.sv
// Self-checking bench for issue_sched: directed scenarios plus random
// traffic compared against a queue-based reference model.
`timescale 1ns/1ps
module tb_issue_sched;

    localparam int QD = 4;

`ifdef DUAL_ISSUE_EN
    localparam logic [1:0] WANT_PAIR = 2'b11;
`else
    localparam logic [1:0] WANT_PAIR = 2'b01;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    issue_sched_if #(.QDEPTH(QD), .PC_W(32), .RA_W(5)) bus ();

    issue_sched #(.QDEPTH(QD), .PC_W(32), .RA_W(5)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [31:0] pc;
        logic [31:0] npc;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic        we;
        logic        br;
        int          idx;
    } ins_t;

    typedef struct {
        logic [1:0] v;
        ins_t       i0;
        ins_t       i1;
        logic       stop;
        logic       flush;
    } stim_t;

    int errors = 0;
    int checks = 0;

    ins_t         mq[$];
    logic [4:0]   mbusy[$];
    int           mhd;
    logic         mseq;
    int           m_na;
    stim_t        cur;
    logic [136:0] exp_vec;

    function automatic ins_t mk(logic [31:0] pc, logic [4:0] rd,
                                logic [4:0] rs1, logic [4:0] rs2,
                                logic we, logic br);
        ins_t t;
        t.pc = pc; t.npc = pc + 32'd4;
        t.rd = rd; t.rs1 = rs1; t.rs2 = rs2;
        t.we = we; t.br = br; t.idx = 0;
        return t;
    endfunction

    function automatic stim_t st(logic [1:0] v, ins_t a, ins_t b,
                                 logic stop, logic flush);
        stim_t s;
        s.v = v; s.i0 = a; s.i1 = b; s.stop = stop; s.flush = flush;
        return s;
    endfunction

    function automatic stim_t idle();
        return st(2'b00, mk(0, 0, 0, 0, 0, 0), mk(0, 0, 0, 0, 0, 0),
                  1'b0, 1'b0);
    endfunction

    function automatic ins_t rnd_ins();
        return mk($urandom, 5'($urandom_range(0, 7)),
                  5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                  $urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0);
    endfunction

    function automatic logic [136:0] obs();
        return {bus.enq_ready, bus.iss_valid,
                bus.iss_pc0, bus.iss_npc0, bus.iss_idx0, bus.iss_num0,
                bus.iss_pc1, bus.iss_npc1, bus.iss_idx1, bus.iss_num1};
    endfunction

    function automatic bit busy(logic [4:0] r);
        if (r == 5'd0) return 1'b0;
        foreach (mbusy[k]) if (mbusy[k] == r) return 1'b1;
        return 1'b0;
    endfunction

    task automatic mreset();
        mq.delete();
        mbusy.delete();
        mhd  = 0;
        mseq = 1'b0;
    endtask

    // Expected outputs from the program-order queue and busy-reg list.
    task automatic model_eval();
        int n;
        logic [31:0] pc0, npc0, pc1, npc1;
        logic [1:0]  ix0, ix1;
        logic        nm0, nm1;
        ins_t a, b;
        n = 0;
        pc0 = 0; npc0 = 0; pc1 = 0; npc1 = 0;
        ix0 = 0; ix1 = 0; nm0 = 0; nm1 = 0;
        if (mq.size() >= 1 && !cur.stop && !cur.flush &&
            !busy(mq[0].rs1) && !busy(mq[0].rs2))
            n = 1;
`ifdef DUAL_ISSUE_EN
        if (n == 1 && mq.size() >= 2) begin
            a = mq[0];
            b = mq[1];
            if (!a.br && !busy(b.rs1) && !busy(b.rs2) &&
                !(a.we && a.rd != 0 && (a.rd == b.rs1 || a.rd == b.rs2)) &&
                !(a.we && b.we && a.rd == b.rd && a.rd != 0))
                n = 2;
        end
`endif
        if (n >= 1) begin
            pc0 = mq[0].pc; npc0 = mq[0].npc;
            ix0 = 2'(mq[0].idx); nm0 = mseq;
        end
        if (n >= 2) begin
            pc1 = mq[1].pc; npc1 = mq[1].npc;
            ix1 = 2'(mq[1].idx); nm1 = ~mseq;
        end
        m_na = n;
        exp_vec = {mq.size() <= QD - 2,
                   n == 2 ? 2'b11 : (n == 1 ? 2'b01 : 2'b00),
                   pc0, npc0, ix0, nm0, pc1, npc1, ix1, nm1};
    endtask

    task automatic model_commit();
        int   tl;
        bit   rdy;
        ins_t t;
        tl  = (mhd + mq.size()) % QD;
        rdy = mq.size() <= QD - 2;
        if (!cur.stop) begin
            mbusy.delete();
            for (int k = 0; k < m_na; k++)
                if (mq[k].we) mbusy.push_back(mq[k].rd);
        end
`ifdef DUAL_ISSUE_EN
        if (m_na == 1) mseq = ~mseq;
`endif
        for (int k = 0; k < m_na; k++) void'(mq.pop_front());
        mhd = (mhd + m_na) % QD;
        if (cur.flush) begin
            mq.delete();
            mhd = tl;
        end else if (rdy) begin
            if (cur.v[0]) begin
                t = cur.i0; t.idx = tl; mq.push_back(t);
            end
            if (cur.v[1]) begin
                t = cur.i1; t.idx = (tl + 1) % QD; mq.push_back(t);
            end
        end
    endtask

    task automatic drive(stim_t s);
        cur = s;
        bus.enq_valid = s.v;
        bus.enq_pc0   = s.i0.pc;  bus.enq_pc1  = s.i1.pc;
        bus.enq_npc0  = s.i0.npc; bus.enq_npc1 = s.i1.npc;
        bus.enq_rs1_0 = s.i0.rs1; bus.enq_rs2_0 = s.i0.rs2;
        bus.enq_rd_0  = s.i0.rd;
        bus.enq_rs1_1 = s.i1.rs1; bus.enq_rs2_1 = s.i1.rs2;
        bus.enq_rd_1  = s.i1.rd;
        bus.enq_we    = {s.i1.we, s.i0.we};
        bus.enq_br    = {s.i1.br, s.i0.br};
        bus.stop      = s.stop;
        bus.flush     = s.flush;
    endtask

    task automatic apply(stim_t s);
        @(negedge clk);
        drive(s);
        #1;
        model_eval();
    endtask

    task automatic advance();
        model_commit();
        @(posedge clk);
    endtask

    task automatic test_reset();
        apply(idle());
        if (bus.enq_ready !== 1'b1 || bus.iss_valid !== 2'b00) begin
            errors++;
            $display("FAIL reset_const ready=%b valid=%b want 1/00",
                     bus.enq_ready, bus.iss_valid);
        end
        checks++;
        if (obs() !== exp_vec) begin
            errors++;
            $display("FAIL reset_state got=%h want=%h", obs(), exp_vec);
        end
        checks++;
        rst = 1'b0;
        advance();
        apply(idle());
        if (obs() !== exp_vec) begin
            errors++;
            $display("FAIL reset_after got=%h want=%h", obs(), exp_vec);
        end
        checks++;
        advance();
    endtask

    task automatic test_dual_pair();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h100, 1, 2, 0, 1, 0),
                       mk(32'h104, 3, 4, 0, 1, 0), 0, 0));
        repeat (3) s.push_back(idle());
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL dual_pair c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            if (c == 1) begin
                if (bus.iss_valid !== WANT_PAIR) begin
                    errors++;
                    $display("FAIL dual_pair_valid got=%b want=%b",
                             bus.iss_valid, WANT_PAIR);
                end
                checks++;
            end
            advance();
        end
    endtask

    task automatic test_raw_chain();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h200, 5, 1, 0, 1, 0),
                       mk(32'h204, 6, 5, 0, 1, 0), 0, 0));
        repeat (4) s.push_back(idle());
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL raw_chain c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            if (c == 2) begin
                if (bus.iss_valid !== 2'b00) begin
                    errors++;
                    $display("FAIL raw_busy got=%b want=00",
                             bus.iss_valid);
                end
                checks++;
            end
            advance();
        end
    endtask

    task automatic test_branch_flush();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h300, 8, 9, 0, 1, 1),
                       mk(32'h304, 10, 11, 0, 1, 0), 0, 0));
        repeat (3) s.push_back(idle());
        s.push_back(st(2'b11, mk(32'h380, 8, 9, 0, 1, 1),
                       mk(32'h384, 10, 11, 0, 1, 0), 0, 0));
        s.push_back(idle());
        s.push_back(st(2'b11, mk(32'h400, 12, 1, 2, 1, 0),
                       mk(32'h404, 13, 3, 4, 1, 0), 0, 1));
        repeat (2) s.push_back(idle());
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL branch_flush c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_full();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h500, 12, 16, 17, 1, 0),
                       mk(32'h504, 13, 18, 19, 1, 0), 1, 0));
        s.push_back(st(2'b11, mk(32'h508, 14, 16, 17, 1, 0),
                       mk(32'h50c, 15, 18, 19, 1, 0), 1, 0));
        s.push_back(st(2'b11, mk(32'h510, 20, 1, 2, 1, 0),
                       mk(32'h514, 21, 3, 4, 1, 0), 1, 0));
        s.push_back(idle());
        repeat (4) s.push_back(idle());
        s.push_back(st(2'b11, mk(32'h520, 22, 1, 2, 1, 0),
                       mk(32'h524, 23, 3, 4, 1, 0), 0, 0));
        repeat (2) s.push_back(idle());
        s[3].stop = 1'b1;
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL full c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            if (c == 2) begin
                if (bus.enq_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL full_ready got=%b want=0",
                             bus.enq_ready);
                end
                checks++;
            end
            advance();
        end
    endtask

    task automatic test_waw_x0();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h600, 7, 1, 2, 1, 0),
                       mk(32'h604, 7, 3, 4, 1, 0), 0, 0));
        repeat (3) s.push_back(idle());
        s.push_back(st(2'b11, mk(32'h700, 0, 0, 0, 1, 0),
                       mk(32'h704, 0, 0, 0, 1, 0), 0, 0));
        repeat (2) s.push_back(idle());
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL waw_x0 c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            advance();
        end
    endtask

    task automatic test_async_rst();
        stim_t s[$];
        s.push_back(st(2'b11, mk(32'h800, 24, 1, 2, 1, 0),
                       mk(32'h804, 25, 3, 4, 1, 0), 1, 0));
        s.push_back(st(2'b11, mk(32'h808, 26, 1, 2, 1, 0),
                       mk(32'h80c, 27, 3, 4, 1, 0), 1, 0));
        s.push_back(idle());
        foreach (s[c]) begin
            apply(s[c]);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL async_pre c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            advance();
        end
        apply(idle());
        #2 rst = 1'b1;
        #1;
        if (bus.iss_valid !== 2'b00 || bus.enq_ready !== 1'b1) begin
            errors++;
            $display("FAIL async_rst valid=%b ready=%b want 00/1",
                     bus.iss_valid, bus.enq_ready);
        end
        checks++;
        mreset();
        model_eval();
        if (obs() !== exp_vec) begin
            errors++;
            $display("FAIL async_rst_all got=%h want=%h", obs(), exp_vec);
        end
        checks++;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        apply(idle());
        if (obs() !== exp_vec) begin
            errors++;
            $display("FAIL async_post got=%h want=%h", obs(), exp_vec);
        end
        checks++;
        advance();
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            stim_t s;
            int    r;
            r = $urandom_range(0, 9);
            s.v = (r < 3) ? 2'b00 : ((r < 5) ? 2'b01 : 2'b11);
            s.i0 = rnd_ins();
            s.i1 = rnd_ins();
            s.stop = ($urandom_range(0, 4) == 0);
            s.flush = ($urandom_range(0, 19) == 0);
            apply(s);
            if (obs() !== exp_vec) begin
                errors++;
                $display("FAIL random c%0d got=%h want=%h",
                         c, obs(), exp_vec);
            end
            checks++;
            advance();
        end
    endtask

    initial begin
        drive(idle());
        mreset();
        test_reset();
        test_dual_pair();
        test_raw_chain();
        test_branch_flush();
        test_full();
        test_waw_x0();
        test_async_rst();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
